load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit sitting directly downstream of the ALU in the CPU datapath. It consumes the ALU result as the effective address, rs2 data as store data, and funct3 as the access size. It drives a request/ready handshake to data memory, and returns sign- or zero-extended load data to the writeback path. While an access is in flight it raises Stall so the core freezes PC and register writes. Misaligned, illegal, or timed-out accesses are reported as faults instead of reaching memory.

## Interface
- MAX_WAIT, 16: maximum consecutive cycles mem_req may wait for mem_ready; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from control; sampled only in IDLE.
- MemWrite  in  1  store request from control; sampled only in IDLE.
- funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores).
- Address  in  32  effective byte address (ALU result).
- StoreData  in  32  store data (rs2).
- Stall  out  1  high while the core must hold its current instruction.
- LoadData  out  32  extended load result; meaningful only while LoadValid is high.
- LoadValid  out  1  one-cycle pulse, concurrent with the commit cycle of a load.
- Fault  out  1  one-cycle pulse, concurrent with the commit cycle of a faulting access.
- FaultCause  out  2  01 misaligned, 10 timeout, 11 illegal; 00 whenever Fault is low.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, {Address[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables (bit i = byte lane i).
- mem_ready  in  1  memory accept; read data valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, ACCESS, RESP, FAULT. Reset state is IDLE.
- IDLE, no request: all outputs 0.
- IDLE, request present: latch funct3, Address, StoreData and the read/write flag, then classify the request:
  - Illegal: MemRead and MemWrite both high, a load funct3 outside {000,001,010,100,101}, or a store funct3 outside {000,001,010}. Next state FAULT, cause 11.
  - Misaligned: halfword with Address[0]=1, or word with Address[1:0]≠00. Next state FAULT, cause 01.
  - Otherwise: next state ACCESS, wait counter cleared to 0.
- ACCESS: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata are driven from latched values and stay constant.
  - mem_ready=1: capture the extracted load value (loads only); next state RESP.
  - mem_ready=0 and counter==MAX_WAIT-1: next state FAULT, cause 10.
  - mem_ready=0 otherwise: counter increments.
- RESP: LoadValid=1 for loads (0 for stores), LoadData driven from the registered value. Next state IDLE unconditionally; MemRead/MemWrite are ignored this cycle.
- FAULT: Fault=1, FaultCause valid, no memory access. Next state IDLE unconditionally; inputs are ignored.
- Byte enables:
  - Byte access: 0001 shifted left by Address[1:0].
  - Half access: 0011 if Address[1]=0, else 1100.
  - Word access: 1111.
- Store data: SB replicates StoreData[7:0] to all 4 lanes; SH replicates [15:0] to both halves; SW passes through.
- Load extraction:
  - Byte: lane Address[1:0] of mem_rdata.
  - Half: bits [31:16] if Address[1]=1, else [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_ready outside ACCESS is ignored.
- The unit never issues a second request without first returning to IDLE.

## Timing
- Stall is combinational: high in IDLE when MemRead|MemWrite, high in ACCESS, low in RESP, FAULT and idle IDLE.
- Request accepted at cycle T (IDLE):
  - T+1: mem_req high (ACCESS).
  - mem_ready at T+k (k≥1): RESP at T+k+1, Stall low, and the instruction commits at the end of that cycle.
  - Minimum stall: 2 cycles (T, T+1).
- Timeout: mem_req is high for exactly MAX_WAIT cycles. Fault pulses in the following cycle.
- Misaligned or illegal: Stall high for exactly 1 cycle (T); Fault at T+1; mem_req never asserted.
- Registered outputs (mem_*, LoadData, LoadValid, Fault, FaultCause) change only on clock edges.
- Reset:
  - Assertion at any time, including mid-ACCESS, forces IDLE asynchronously, clears all outputs and the wait counter, and drops mem_req immediately.
  - Reset release takes effect on the next rising edge.

## Test plan
- LW, Address 0x00000100, mem_ready=1 in the first ACCESS cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111, mem_we 0; Stall high 2 cycles; LoadData 0xDEADBEEF with LoadValid high for 1 cycle.
- LB at 0x103 with mem_rdata 0x80FF0000 -> LoadData 0xFFFFFF80. Same access as LBU -> 0x00000080. LH at 0x102 with mem_rdata 0x8001xxxx -> 0xFFFF8001.
- SH at 0x102, StoreData 0x1234ABCD, mem_ready delayed 3 cycles -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1; mem_* stable across the wait; Stall high 4 cycles; LoadValid never asserted.
- Misaligned and illegal requests:
  - LW at 0x101 -> Fault pulse, FaultCause 01, mem_req never high, Stall high 1 cycle.
  - MemRead=MemWrite=1 -> FaultCause 11.
- Timeout with MAX_WAIT=4 and mem_ready tied 0 -> mem_req high exactly 4 cycles, then Fault with FaultCause 10, then IDLE. A following LW completes normally.
- Reset: rst driven low during the 2nd ACCESS cycle -> mem_req, Stall and all outputs 0 without waiting for a clock edge. After release, a new SW at 0x200 is issued with mem_be 1111.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: classifies requests, drives a req/ready handshake
// with a bounded wait, and returns extended load data or a fault cause.
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] Address,
   input  logic [31:0] StoreData,
   output logic        Stall,
   output logic [31:0] LoadData,
   output logic        LoadValid,
   output logic        Fault,
   output logic [1:0]  FaultCause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   state_t      state_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  offset_reg;
   logic [7:0]  wait_reg;

   logic        request;
   logic        illegal_next;
   logic        misaligned_next;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_next;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [7:0]  rdata_lane [4];

   assign request = MemRead | MemWrite;
   assign Stall   = ((state_reg == IDLE) && request) || (state_reg == ACCESS);

   // Request classification; an illegal encoding takes precedence over misalignment.
   always_comb begin
      illegal_next    = 1'b0;
      misaligned_next = 1'b0;
      if (MemRead && MemWrite)
         illegal_next = 1'b1;
      else if (MemRead && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
         illegal_next = 1'b1;
      else if (MemWrite && !(funct3 inside {3'b000, 3'b001, 3'b010}))
         illegal_next = 1'b1;
      if (funct3[1:0] == 2'b01 && Address[0])
         misaligned_next = 1'b1;
      else if (funct3[1:0] == 2'b10 && Address[1:0] != 2'b00)
         misaligned_next = 1'b1;
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = StoreData;
      case (funct3[1:0])
         2'b00: begin
            be_next    = 4'b0001 << Address[1:0];
            wdata_next = {4{StoreData[7:0]}};
         end
         2'b01: begin
            be_next    = Address[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{StoreData[15:0]}};
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rdata_lane[gi] = mem_rdata[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = rdata_lane[offset_reg];
   assign half_sel = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_next = mem_rdata;
      case (funct3_reg)
         3'b000:  load_next = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_next = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_next = {24'd0, byte_sel};
         3'b101:  load_next = {16'd0, half_sel};
         default: load_next = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         funct3_reg <= 3'd0;
         offset_reg <= 2'd0;
         wait_reg   <= 8'd0;
         LoadData   <= 32'd0;
         LoadValid  <= 1'b0;
         Fault      <= 1'b0;
         FaultCause <= 2'b00;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_be     <= 4'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (request) begin
                  funct3_reg <= funct3;
                  offset_reg <= Address[1:0];
                  if (illegal_next) begin
                     state_reg  <= FAULT;
                     Fault      <= 1'b1;
                     FaultCause <= CAUSE_ILLEGAL;
                  end else if (misaligned_next) begin
                     state_reg  <= FAULT;
                     Fault      <= 1'b1;
                     FaultCause <= CAUSE_MISALIGN;
                  end else begin
                     state_reg <= ACCESS;
                     wait_reg  <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= MemWrite;
                     mem_addr  <= {Address[31:2], 2'b00};
                     mem_be    <= be_next;
                     mem_wdata <= wdata_next;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready || wait_reg == WAIT_LAST) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'd0;
                  mem_be    <= 4'd0;
                  mem_wdata <= 32'd0;
               end
               if (mem_ready) begin
                  state_reg <= RESP;
                  LoadValid <= !mem_we;
                  LoadData  <= mem_we ? 32'd0 : load_next;
               end else if (wait_reg == WAIT_LAST) begin
                  state_reg  <= FAULT;
                  Fault      <= 1'b1;
                  FaultCause <= CAUSE_TIMEOUT;
               end else begin
                  wait_reg <= wait_reg + 8'd1;
               end
            end
            RESP: begin
               state_reg <= IDLE;
               LoadValid <= 1'b0;
               LoadData  <= 32'd0;
            end
            FAULT: begin
               state_reg  <= IDLE;
               Fault      <= 1'b0;
               FaultCause <= 2'b00;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-level memory-access model.
`timescale 1ns/1ps
module tb_load_store_unit;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] Address, StoreData;
   logic        Stall;
   logic [31:0] LoadData;
   logic        LoadValid, Fault;
   logic [1:0]  FaultCause;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   load_store_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
      .Address(Address), .StoreData(StoreData), .Stall(Stall), .LoadData(LoadData),
      .LoadValid(LoadValid), .Fault(Fault), .FaultCause(FaultCause), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference model: 0 ok, 1 misaligned, 3 illegal.
   function automatic int classify(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
      int size;
      if (rd && wr) return 3;
      if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 3;
      if (wr && f3 > 2) return 3;
      size = 1 << f3[1:0];
      if ((addr % size) != 0) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      if (f3[1:0] == 2'b00) begin
         v = (rdata >> (addr[1:0] * 8)) & 32'hFF;
         if (f3[2] == 1'b0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (f3[1:0] == 2'b01) begin
         v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
         if (f3[2] == 1'b0 && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be;
      int size, off;
      size = 1 << f3[1:0];
      off  = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3[1:0] == 2'b00) return (sd & 32'hFF) * 32'h01010101;
      if (f3[1:0] == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   // Entered and left at a falling edge with the unit idle; lat = ACCESS cycle index of mem_ready.
   task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input int lat);
      int cause, stall_cycles;
      logic [31:0] exp_load;
      cause    = classify(rd, wr, f3, addr);
      exp_load = model_load(f3, addr, rdata);
      $display("txn rd=%0b wr=%0b f3=%0d addr=%h sd=%h rdata=%h lat=%0d cause=%0d",
               rd, wr, f3, addr, sd, rdata, lat, cause);
      MemRead = rd; MemWrite = wr; funct3 = f3; Address = addr; StoreData = sd;
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      #1 check("stall_req", 32'(Stall), 32'd1);
      stall_cycles = 1;
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; Address = $urandom; StoreData = $urandom;
      if (cause != 0) begin
         check("fault_pulse", 32'({Fault, FaultCause, mem_req, Stall}),
               32'({1'b1, 2'(cause), 1'b0, 1'b0}));
      end else begin
         for (int n = 0; n < MW; n++) begin
            check("acc_ctl", 32'({mem_req, mem_we, mem_be, Stall, LoadValid}),
                  32'({1'b1, wr, model_be(f3, addr), 1'b1, 1'b0}));
            check("acc_addr", mem_addr, addr & 32'hFFFFFFFC);
            if (wr) check("acc_wdata", mem_wdata, model_wdata(f3, sd));
            stall_cycles++;
            mem_ready = (n == lat);
            mem_rdata = (n == lat) ? rdata : $urandom;
            @(negedge clk);
            if (n == lat) break;
         end
         mem_ready = 1'($urandom);
         if (lat < MW) begin
            check("resp_ctl", 32'({mem_req, Stall, LoadValid, Fault}),
                  32'({1'b0, 1'b0, rd, 1'b0}));
            check("stall_len", 32'(stall_cycles), 32'(lat + 2));
            if (rd) check("load_data", LoadData, exp_load);
         end else begin
            check("timeout", 32'({Fault, FaultCause, mem_req, Stall}), 32'({1'b1, 2'b10, 1'b0, 1'b0}));
            check("timeout_len", 32'(stall_cycles), 32'(MW + 1));
         end
      end
      @(negedge clk);
      check("back_idle", 32'({Fault, FaultCause, LoadValid, mem_req, Stall}), 32'd0);
   endtask

   initial begin
      #1000000 $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
      Address = 32'd0; StoreData = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_ctl", 32'({mem_req, mem_we, mem_be, Stall, LoadValid, Fault, FaultCause}), 32'd0);
      check("reset_data", mem_addr | mem_wdata | LoadData, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0);
      run_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
      run_txn(1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0);
      run_txn(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2);
      run_txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
      run_txn(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
      run_txn(1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0);
      run_txn(1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 100);
      run_txn(1, 0, 3'b010, 32'h44, 32'h0, 32'h13572468, MW - 1);

      // Asynchronous reset in the second ACCESS cycle.
      MemRead = 1'b1; funct3 = 3'b010; Address = 32'h100; mem_ready = 1'b0;
      @(negedge clk);
      MemRead = 1'b0;
      @(negedge clk);
      check("pre_rst_req", 32'({mem_req, Stall}), 32'b11);
      #2 rst = 1'b0;
      #1 check("async_rst_ctl", 32'({mem_req, mem_we, mem_be, Stall, LoadValid, Fault, FaultCause}), 32'd0);
      check("async_rst_data", mem_addr | mem_wdata | LoadData, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_txn(0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 0);

      for (int t = 0; t < 60; t++) begin
         int kind;
         logic [2:0]  f3;
         logic [31:0] addr;
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         if (kind == 0) begin
            MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
            #1 check("idle_zero", 32'({mem_req, Stall, LoadValid, Fault, FaultCause}), 32'd0);
            $display("txn idle");
            @(negedge clk);
         end else begin
            run_txn(kind <= 5, kind == 1 || kind >= 6, f3, addr, $urandom, $urandom,
                    $urandom_range(0, MW + 1));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
